// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter and the memory it fronts.
package dmem_pkg;

  localparam int unsigned MEM_BYTES = 1024;

  typedef enum logic [2:0] {
    MODE_BYTE = 3'b000,
    MODE_HALF = 3'b001,
    MODE_WORD = 3'b010
  } mem_mode_e;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

endpackage

// File: rtl/dmem_arbiter.sv
// Arbitrates the data memory between the MEM-stage core port and a burst DMA port.
// Core has fixed priority; a saturating wait counter forces one DMA beat through.
module dmem_arbiter #(
  parameter int unsigned MEM_BYTES = dmem_pkg::MEM_BYTES,
  parameter int unsigned MAX_WAIT  = 4,
  parameter int unsigned LEN_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             c_req,
  input  logic             c_we,
  input  logic [2:0]       c_mode,
  input  logic [31:0]      c_addr,
  input  logic [31:0]      c_wdata,
  output logic             c_stall,
  output logic [31:0]      c_rdata,
  input  logic             d_start,
  input  logic             d_we,
  input  logic [31:0]      d_base,
  input  logic [LEN_W-1:0] d_len,
  input  logic [31:0]      d_wdata,
  output logic             d_ack,
  output logic             d_rvalid,
  output logic [31:0]      d_rdata,
  output logic             d_busy,
  output logic             d_done,
  output logic             m_we,
  output logic [2:0]       m_mode,
  output logic [31:0]      m_addr,
  output logic [31:0]      m_wdata,
  input  logic [31:0]      m_rdata
);

  import dmem_pkg::*;

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

  arb_state_e       state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [LEN_W-1:0] left_q, left_d;
  logic             we_q, we_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic             done_q, rvalid_q;
  logic [31:0]      rdata_q;
  logic             dma_gnt, last_beat;

  // DMA grant is masked while reset is asserted so an aborted burst never writes.
  assign dma_gnt   = rst && (state_q == BURST) && (!c_req || (wait_q == WAIT_W'(MAX_WAIT)));
  assign last_beat = dma_gnt && (left_q == LEN_W'(1));

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (d_start && (d_len != '0)) state_d = BURST;
      BURST:   if (last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    d_busy  = (state_q == BURST);
    d_ack   = dma_gnt;
    c_stall = c_req && dma_gnt;
    if (dma_gnt) begin
      m_we    = we_q;
      m_mode  = MODE_WORD;
      m_addr  = addr_q;
      m_wdata = d_wdata;
    end else begin
      m_we    = c_req && c_we;
      m_mode  = c_mode;
      m_addr  = c_addr;
      m_wdata = c_wdata;
    end
  end

  always_comb begin
    addr_d = addr_q;
    left_d = left_q;
    we_d   = we_q;
    wait_d = wait_q;
    if (state_q == IDLE) begin
      wait_d = '0;
      if (d_start && (d_len != '0)) begin
        addr_d = d_base;
        left_d = d_len;
        we_d   = d_we;
      end
    end else if (dma_gnt) begin
      addr_d = (addr_q + 32'd4) % MEM_BYTES;
      left_d = left_q - LEN_W'(1);
      wait_d = '0;
    end else if (wait_q != WAIT_W'(MAX_WAIT)) begin
      wait_d = wait_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q   <= '0;
      left_q   <= '0;
      we_q     <= 1'b0;
      wait_q   <= '0;
      done_q   <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      addr_q   <= addr_d;
      left_q   <= left_d;
      we_q     <= we_d;
      wait_q   <= wait_d;
      done_q   <= last_beat;
      rvalid_q <= dma_gnt && !we_q;
      if (dma_gnt && !we_q) rdata_q <= m_rdata;
    end
  end

  assign d_done   = done_q;
  assign d_rvalid = rvalid_q;
  assign d_rdata  = rdata_q;
  assign c_rdata  = m_rdata;

endmodule
